// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and width default for the ALU execute stage.
// Optional signed multiply is enabled by defining SIGNED_MUL_EN.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] FS_PASS_R = 4'h0;
  localparam logic [3:0] FS_PASS_S = 4'h1;
  localparam logic [3:0] FS_INC    = 4'h2;
  localparam logic [3:0] FS_DEC    = 4'h3;
  localparam logic [3:0] FS_ADD    = 4'h4;
  localparam logic [3:0] FS_SUB    = 4'h5;
  localparam logic [3:0] FS_AND    = 4'h6;
  localparam logic [3:0] FS_OR     = 4'h7;
  localparam logic [3:0] FS_XOR    = 4'h8;
  localparam logic [3:0] FS_NOT    = 4'h9;
  localparam logic [3:0] FS_SHL    = 4'hA;
  localparam logic [3:0] FS_SHR    = 4'hB;
  localparam logic [3:0] FS_MUL    = 4'hC;
  localparam logic [3:0] FS_MULS   = 4'hD;
  localparam logic [3:0] FS_ZERO   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// done is high during the final iteration; product is the value it produces.
module alu_seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT1 = CW'(1);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               busy_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper;

  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    upper   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    product = {upper, acc[WIDTH-1:1]};
    done    = busy_q && (cnt == LAST);
  end

  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc    <= product;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative multiply, registered Y/flags.
// Define SIGNED_MUL_EN to make FS=D a signed multiply; otherwise D is reserved.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       FS,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Y_lo,
  output logic [WIDTH-1:0] Y_hi,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_d;

  logic [WIDTH-1:0] y_lo_q, y_lo_d;
  logic [WIDTH-1:0] y_hi_q, y_hi_d;
  logic             c_q, c_d;
  logic             n_q, n_d;
  logic             z_q, z_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               is_mul;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sum   = '0;
    alu_y = '0;
    alu_c = 1'b0;
    unique case (FS)
      FS_PASS_R: alu_y = R;
      FS_PASS_S: alu_y = S;
      FS_INC: begin
        sum   = {1'b0, R} + ONE_X;
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      FS_DEC: begin
        alu_y = R - ONE;
        alu_c = |R;
      end
      FS_ADD: begin
        sum   = {1'b0, R} + {1'b0, S};
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      FS_SUB: begin
        sum   = {1'b0, R} + {1'b0, ~S} + ONE_X;
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      FS_AND: alu_y = R & S;
      FS_OR:  alu_y = R | S;
      FS_XOR: alu_y = R ^ S;
      FS_NOT: alu_y = ~R;
      FS_SHL: begin
        alu_y = {R[WIDTH-2:0], 1'b0};
        alu_c = R[WIDTH-1];
      end
      FS_SHR: begin
        alu_y = {1'b0, R[WIDTH-1:1]};
        alu_c = R[0];
      end
      default: begin
        alu_y = '0;
        alu_c = 1'b0;
      end
    endcase
  end

`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d;
  logic is_muls;

  // Signed multiply runs on magnitudes; the sign is reapplied at capture.
  always_comb begin
    is_muls = (FS == FS_MULS);
    is_mul  = (FS == FS_MUL) || is_muls;
    mul_a   = (is_muls && R[WIDTH-1]) ? -R : R;
    mul_b   = (is_muls && S[WIDTH-1]) ? -S : S;
    neg_d   = neg_q;
    if (state == ST_IDLE && start && is_mul)
      neg_d = is_muls && (R[WIDTH-1] ^ S[WIDTH-1]);
    prod    = neg_q ? -mul_prod : mul_prod;
  end

  always_ff @(posedge clk) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  always_comb begin
    is_mul = (FS == FS_MUL);
    mul_a  = R;
    mul_b  = S;
    prod   = mul_prod;
  end
`endif

  alu_seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (mul_a),
    .b      (mul_b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_prod)
  );

  always_comb begin
    state_d   = state;
    mul_start = 1'b0;
    y_lo_d    = y_lo_q;
    y_hi_d    = y_hi_q;
    c_d       = c_q;
    n_d       = n_q;
    z_d       = z_q;
    unique case (state)
      ST_IDLE: begin
        if (start && is_mul) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end else if (start) begin
          y_lo_d  = alu_y;
          y_hi_d  = '0;
          c_d     = alu_c;
          n_d     = alu_y[WIDTH-1];
          z_d     = (alu_y == '0);
          state_d = ST_DONE;
        end
      end
      ST_MUL: begin
        // Capture the final iteration directly so done lands WIDTH+1 clocks out.
        if (mul_done) begin
          y_hi_d  = prod[2*WIDTH-1:WIDTH];
          y_lo_d  = prod[WIDTH-1:0];
          c_d     = |prod[2*WIDTH-1:WIDTH];
          n_d     = prod[2*WIDTH-1];
          z_d     = (prod == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      y_lo_q <= '0;
      y_hi_q <= '0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      state  <= state_d;
      y_lo_q <= y_lo_d;
      y_hi_q <= y_hi_d;
      c_q    <= c_d;
      n_q    <= n_d;
      z_q    <= z_d;
    end
  end

  assign Y_lo = y_lo_q;
  assign Y_hi = y_hi_q;
  assign C    = c_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign busy = (state == ST_MUL) && mul_busy;
  assign done = (state == ST_DONE);

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the 8x16 register file.
- Consumes the register file's two read-port outputs (R, S) and an operation select; produces a registered result plus C/N/Z status flags.
- The result's low word is what control routes back to the register file's W write-data input.
- Single-cycle logic/arithmetic ops; a multi-cycle shift-add unsigned multiply with a start/busy/done handshake so the control unit can hold write-enable until the result is valid.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH; multiply iterations = WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- FS  input  4  operation select, latched with operands on an accepted start.
- R  input  WIDTH  operand A (register file R port).
- S  input  WIDTH  operand B (register file S port).
- Y_lo  output  WIDTH  result low word / write-back data.
- Y_hi  output  WIDTH  product high word; 0 for non-multiply ops.
- C  output  1  carry/borrow/shift-out flag.
- N  output  1  negative flag.
- Z  output  1  zero flag.
- busy  output  1  high while a multiply iterates.
- done  output  1  one-cycle pulse: outputs valid/updated this cycle.

Behaviour:
- Reset (synchronous, checked first, overrides start):
  - Y_lo=0, Y_hi=0, C=0, N=0, Z=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Reset mid-multiply aborts it with no done pulse.
- FS encoding:
  - 0 PASS_R, 1 PASS_S, 2 INC R, 3 DEC R, 4 ADD R+S, 5 SUB R-S, 6 AND, 7 OR, 8 XOR, 9 NOT R, A SHL R, B SHR R (logical), C MUL, D MULS (optional), E ZERO, F reserved.
- States: IDLE, MUL, DONE.
- IDLE, start=1 with a non-multiply FS:
  - The result is registered at that edge and the next state is DONE, so done=1 during the cycle right after the start edge (latency 1).
  - Y_hi=0.
- IDLE, start=1 with FS=C:
  - Latch R as multiplicand and S as multiplier; clear the 2*WIDTH accumulator and counter; busy=1; state=MUL.
- MUL:
  - Each cycle adds the multiplicand to the accumulator's upper half if the multiplier LSB is 1, then shifts right one bit; counter increments.
  - After WIDTH iterations, {Y_hi,Y_lo}=product, busy=0, state=DONE.
  - done asserts WIDTH+1 clocks after the start edge (17 at default).
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start during DONE is ignored.
  - Y/flags hold until the next completed operation.
- start while busy=1 is ignored; R/S/FS changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH:
  - ADD: C=carry-out.
  - SUB: computed as R+~S+1; C=carry-out (1 when R>=S unsigned).
  - INC: C=carry-out (0xFFFF→0x0000, C=1).
  - DEC: C=1 when R≠0.
  - SHL: C=R[WIDTH-1].
  - SHR: C=R[0].
  - Logic, PASS, ZERO: C=0.
  - MUL: C=(Y_hi≠0).
- N=Y_lo[WIDTH-1], except MUL/MULS where N=Y_hi[WIDTH-1].
- Z=(Y_lo==0) for single-cycle ops; Z=({Y_hi,Y_lo}==0) for MUL/MULS.
- Reserved/disabled FS: result 0, C=0, N=0, Z=1, latency 1.

Optional Feature:
- Macro SIGNED_MUL_EN.
- When defined, FS=D is a signed two's-complement multiply:
  - Operand magnitudes feed the same iterative unit, with identical latency.
  - The product is negated if the operand signs differ.
  - -1 × 1 = 0xFFFF_FFFF; 0x8000 × 0x8000 = 0x4000_0000.
- When undefined, FS=D is reserved (result 0, Z=1, latency 1) and no extra logic is synthesized.

Decomposition:
- Package alu_pkg:
  - FS opcode localparams (FS_PASS_R … FS_ZERO).
  - State encoding constants (ST_IDLE, ST_MUL, ST_DONE).
  - The WIDTH default.
- One natural sub-module: alu_seq_multiplier, holding the shift-add datapath and counter with start/busy/done.
- The top holds the combinational single-cycle ops, flag generation, the FSM, and output registers.

Test Plan:
- Reset for 1 cycle, then idle 3 cycles -> all outputs 0, busy=0, done never pulses.
- FS=4, R=0xFFFF, S=0x0001, start 1 cycle -> next cycle done=1, Y_lo=0x0000, C=1, Z=1, N=0, Y_hi=0.
- FS=5, R=0x0003, S=0x0005 -> Y_lo=0xFFFE, C=0, N=1, Z=0; FS=B, R=0x8001 -> Y_lo=0x4000, C=1.
- FS=C, R=0x1234, S=0x0100, start; toggle R/S and pulse start while busy -> busy=1 for 16 cycles, done at cycle 17, {Y_hi,Y_lo}=0x0012_3400, C=1; the second start is ignored.
- FS=C, R=0xFFFF, S=0xFFFF, reset asserted at iteration 8 -> no done, outputs 0, busy=0 next cycle; then a fresh MUL completes with 0xFFFE_0001.
- With SIGNED_MUL_EN: FS=D, R=0xFFFD (-3), S=0x0007 -> {Y_hi,Y_lo}=0xFFFF_FFEB, N=1, done at cycle 17.
- Without SIGNED_MUL_EN: FS=D -> Y=0, Z=1, done at cycle 1.
